frame_buf_writer: RTL and testbench

FRAME_BUF_WRITER -- requirements
Module: frame_buf_writer

---
 rtl/frame_buf_writer_if.sv | 12 +
 rtl/frame_buf_writer.sv | 114 +++++++++++
 tb/tb_frame_buf_writer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buf_writer_if.sv
// Pixel stream into the frame buffer writer: one grayscale pixel per cycle
// while pix_valid is high, with a start-of-frame flag and target view select.
`timescale 1ns/1ps
interface frame_buf_writer_if;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_sof;
    logic       pix_eye;

    modport master (output pix_data, pix_valid, pix_sof, pix_eye);
    modport slave  (input  pix_data, pix_valid, pix_sof, pix_eye);
endinterface

// File: rtl/frame_buf_writer.sv
// Writes a quantized 3-bit image stream into a left or right view buffer.
// Optional FRAME_BUF_WRITER_AUTO_EYE_EN: view chosen by an internal toggle flipped per completed frame.
`timescale 1ns/1ps
module frame_buf_writer #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100
) (
    input  logic               vclk,
    input  logic               rst,
    frame_buf_writer_if.slave  pix,
    output logic [15:0]        wraddrl,
    output logic [15:0]        wraddrr,
    output logic [2:0]         wrdatal,
    output logic [2:0]         wrdatar,
    output logic               wrenl,
    output logic               wrenr,
    output logic               wrclkl,
    output logic               wrclkr,
    output logic               done_l,
    output logic               done_r,
    output logic               err_short
);
    localparam int          TOTAL     = IMG_W * IMG_H;
    localparam logic [15:0] LAST_ADDR = 16'(TOTAL - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_reg;
    logic [15:0] addr_reg;
    logic        eye_reg;

    logic        accept_sof;
    logic        accept_pix;
    logic        eye_at_sof;
    logic        sel_eye;
    logic        last_pix;
    logic [15:0] wr_addr;
    logic [8:0]  q_sum;
    logic [2:0]  q_val;

`ifdef FRAME_BUF_WRITER_AUTO_EYE_EN
    logic toggle_reg;
    logic unused_eye;
    assign unused_eye = pix.pix_eye;
    assign eye_at_sof = toggle_reg;
`else
    assign eye_at_sof = pix.pix_eye;
`endif

    assign wrclkl = vclk;
    assign wrclkr = vclk;

    always_comb begin
        // (d+16)>>5 reaches 8 only when the 9-bit sum overflows into bit 8
        q_sum      = {1'b0, pix.pix_data} + 9'd16;
        q_val      = q_sum[8] ? 3'd7 : q_sum[7:5];
        accept_sof = pix.pix_valid & pix.pix_sof;
        accept_pix = accept_sof | (pix.pix_valid & (state_reg == WRITE));
        wr_addr    = accept_sof ? 16'd0 : addr_reg;
        sel_eye    = accept_sof ? eye_at_sof : eye_reg;
        last_pix   = (wr_addr == LAST_ADDR);
    end

    always_ff @(posedge vclk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            eye_reg   <= 1'b0;
            wraddrl   <= '0;
            wraddrr   <= '0;
            wrdatal   <= '0;
            wrdatar   <= '0;
            wrenl     <= 1'b0;
            wrenr     <= 1'b0;
            done_l    <= 1'b0;
            done_r    <= 1'b0;
            err_short <= 1'b0;
`ifdef FRAME_BUF_WRITER_AUTO_EYE_EN
            toggle_reg <= 1'b0;
`endif
        end else begin
            wrenl     <= 1'b0;
            wrenr     <= 1'b0;
            done_l    <= 1'b0;
            done_r    <= 1'b0;
            err_short <= accept_sof & (state_reg == WRITE);
            if (accept_pix) begin
                eye_reg <= sel_eye;
                if (sel_eye) begin
                    wrenr   <= 1'b1;
                    wraddrr <= wr_addr;
                    wrdatar <= q_val;
                end else begin
                    wrenl   <= 1'b1;
                    wraddrl <= wr_addr;
                    wrdatal <= q_val;
                end
                // Finish on the last address so the counter never runs past the view
                if (last_pix) begin
                    state_reg <= IDLE;
                    addr_reg  <= '0;
                    done_r    <= sel_eye;
                    done_l    <= ~sel_eye;
`ifdef FRAME_BUF_WRITER_AUTO_EYE_EN
                    toggle_reg <= ~toggle_reg;
`endif
                end else begin
                    state_reg <= WRITE;
                    addr_reg  <= wr_addr + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_buf_writer.sv
// Randomized bench for frame_buf_writer: a frame-level reference model predicts
// every output cycle by cycle, plus directed scenario checks on counts and values.
`timescale 1ns/1ps
module tb_frame_buf_writer;
    localparam int W = 100;
    localparam int H = 100;
    localparam int N = W * H;

    logic vclk = 1'b0;
    always #5 vclk = ~vclk;

    logic        rst;
    logic [15:0] wraddrl, wraddrr;
    logic [2:0]  wrdatal, wrdatar;
    logic        wrenl, wrenr, wrclkl, wrclkr, done_l, done_r, err_short;

    frame_buf_writer_if pix ();

    frame_buf_writer #(.IMG_W(W), .IMG_H(H)) dut (
        .vclk      (vclk),
        .rst       (rst),
        .pix       (pix),
        .wraddrl   (wraddrl),
        .wraddrr   (wraddrr),
        .wrdatal   (wrdatal),
        .wrdatar   (wrdatar),
        .wrenl     (wrenl),
        .wrenr     (wrenr),
        .wrclkl    (wrclkl),
        .wrclkr    (wrclkr),
        .done_l    (done_l),
        .done_r    (done_r),
        .err_short (err_short)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: frame-level view of the stream
    bit          m_active = 0;
    bit          m_eye    = 0;
    bit          m_toggle = 0;
    int          m_count  = 0;
    logic [15:0] e_addr_l = '0, e_addr_r = '0;
    logic [2:0]  e_data_l = '0, e_data_r = '0;
    bit          e_wl, e_wr, e_dl, e_dr, e_err;

    // Observed-event counters for the directed scenarios
    int          cnt_wl, cnt_wr, cnt_dl, cnt_dr, cnt_err;
    int          done_addr_l, done_addr_r;
    int          n_done;
    logic [7:0]  done_order;

    logic [42:0] obs_vec;
    assign obs_vec = {wrenl, wrenr, done_l, done_r, err_short,
                      wraddrl, wraddrr, wrdatal, wrdatar};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int quant(input int d);
        int q;
        q = (d + 16) / 32;
        return (q > 7) ? 7 : q;
    endfunction

    task automatic clr_counts();
        cnt_wl = 0; cnt_wr = 0; cnt_dl = 0; cnt_dr = 0; cnt_err = 0;
        done_addr_l = -1; done_addr_r = -1;
        n_done = 0; done_order = '0;
    endtask

    // One clock: apply inputs, predict, clock, compare everything
    task automatic drive(input bit r, input bit v, input bit s, input bit e, input logic [7:0] d);
        int   idx;
        bit   ev;
        logic [42:0] exp_vec;
        rst = r;
        pix.pix_valid = v; pix.pix_sof = s; pix.pix_eye = e; pix.pix_data = d;
        e_wl = 0; e_wr = 0; e_dl = 0; e_dr = 0; e_err = 0;
        if (r) begin
            m_active = 0; m_toggle = 0; m_count = 0; m_eye = 0;
            e_addr_l = '0; e_addr_r = '0; e_data_l = '0; e_data_r = '0;
        end else if (v && (s || m_active)) begin
            if (s) begin
                e_err = m_active;
`ifdef FRAME_BUF_WRITER_AUTO_EYE_EN
                ev = m_toggle;
`else
                ev = e;
`endif
                idx = 0;
            end else begin
                ev  = m_eye;
                idx = m_count;
            end
            m_eye = ev;
            if (ev) begin
                e_wr = 1; e_addr_r = 16'(idx); e_data_r = 3'(quant(int'(d)));
            end else begin
                e_wl = 1; e_addr_l = 16'(idx); e_data_l = 3'(quant(int'(d)));
            end
            m_count = idx + 1;
            if (m_count == N) begin
                m_active = 0; m_count = 0; m_toggle = !m_toggle;
                if (ev) e_dr = 1; else e_dl = 1;
            end else begin
                m_active = 1;
            end
        end
        exp_vec = {e_wl, e_wr, e_dl, e_dr, e_err, e_addr_l, e_addr_r, e_data_l, e_data_r};
        @(posedge vclk);
        #1;
        chk("cycle", 64'(obs_vec), 64'(exp_vec));
        if (wrenl) cnt_wl++;
        if (wrenr) cnt_wr++;
        if (err_short) cnt_err++;
        if (done_l) begin cnt_dl++; done_addr_l = int'(wraddrl); end
        if (done_r) begin cnt_dr++; done_addr_r = int'(wraddrr); end
        if ((done_l || done_r) && n_done < 8) begin
            done_order[n_done] = done_r;
            n_done++;
        end
    endtask

    logic [7:0] q_in  [8];
    logic [2:0] q_out [8];

    initial begin
        bit v, s, r;
        q_in[0] = 8'd0;   q_in[1] = 8'd15;  q_in[2] = 8'd16;  q_in[3] = 8'd47;
        q_in[4] = 8'd48;  q_in[5] = 8'd239; q_in[6] = 8'd240; q_in[7] = 8'd255;
        q_out[0] = 3'd0; q_out[1] = 3'd0; q_out[2] = 3'd1; q_out[3] = 3'd1;
        q_out[4] = 3'd2; q_out[5] = 3'd7; q_out[6] = 3'd7; q_out[7] = 3'd7;

        rst = 1'b1;
        pix.pix_valid = 1'b0; pix.pix_sof = 1'b0; pix.pix_eye = 1'b0; pix.pix_data = 8'd0;
        clr_counts();

        // Reset state
        drive(1, 0, 0, 0, 8'd0);
        drive(1, 1, 1, 1, 8'd255);
        chk("reset_state", 64'(obs_vec), 64'd0);
        $display("scenario reset: outputs cleared");

        // Full left frame, constant data 200
        clr_counts();
        for (int i = 0; i < N; i++) drive(0, 1, (i == 0), 0, 8'd200);
        chk("s1_wrenl_count", 64'(cnt_wl), 64'(N));
        chk("s1_wrenr_count", 64'(cnt_wr), 64'd0);
        chk("s1_done_l_count", 64'(cnt_dl), 64'd1);
        chk("s1_done_addr", 64'(done_addr_l), 64'(N - 1));
        chk("s1_wrdatal", 64'(wrdatal), 64'd6);
        $display("scenario left frame: wrenl=%0d done_l=%0d", cnt_wl, cnt_dl);

        // Right frame back-to-back, valid every other cycle
        clr_counts();
        for (int i = 0; i < N; i++) begin
            drive(0, 1, (i == 0), 1, 8'($urandom_range(0, 255)));
            drive(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        end
        chk("s2_wrenr_count", 64'(cnt_wr), 64'(N));
        chk("s2_wrenl_count", 64'(cnt_wl), 64'd0);
        chk("s2_done_r_count", 64'(cnt_dr), 64'd1);
        chk("s2_done_addr", 64'(done_addr_r), 64'(N - 1));
        chk("s2_err_count", 64'(cnt_err), 64'd0);
        $display("scenario right gapped frame: wrenr=%0d done_r=%0d", cnt_wr, cnt_dr);

        // Quantizer sweep, then a 500-pixel left frame cut short by a right SOF
        clr_counts();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, (k == 0), 0, q_in[k]);
            chk("quant", 64'(wrdatal), 64'(q_out[k]));
        end
        for (int i = 8; i < 500; i++) drive(0, 1, 0, 0, 8'($urandom_range(0, 255)));
        drive(0, 1, 1, 1, 8'd100);
        chk("s3_err_short", 64'(err_short), 64'd1);
`ifndef FRAME_BUF_WRITER_AUTO_EYE_EN
        chk("s3_wrenr", 64'(wrenr), 64'd1);
        chk("s3_wraddrr", 64'(wraddrr), 64'd0);
        chk("s3_wraddrl_hold", 64'(wraddrl), 64'd499);
`endif
        chk("s3_no_done", 64'(cnt_dl + cnt_dr), 64'd0);
        $display("scenario quant+short frame: err=%0d", cnt_err);

        // Reset mid-frame at pixel 300, stray pixels ignored, fresh SOF restarts
        for (int i = 1; i < 300; i++) drive(0, 1, 0, 1, 8'($urandom_range(0, 255)));
        clr_counts();
        drive(1, 1, 0, 1, 8'd77);
        chk("s4_reset_outputs", 64'(obs_vec), 64'd0);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 1, 8'($urandom_range(0, 255)));
        chk("s4_ignored_writes", 64'(cnt_wl + cnt_wr), 64'd0);
        chk("s4_no_pulses", 64'(cnt_err + cnt_dl + cnt_dr), 64'd0);
        drive(1, 1, 1, 0, 8'd255);
        chk("s4_rst_priority", 64'(obs_vec), 64'd0);
        drive(0, 1, 1, 0, 8'd255);
        chk("s4_restart", 64'({wrenl, wraddrl, wrdatal}), 64'({1'b1, 16'd0, 3'd7}));
        $display("scenario reset mid-frame: restart at addr %0d", wraddrl);

        // Randomized traffic with occasional early SOF and reset
        clr_counts();
        for (int c = 0; c < 20000; c++) begin
            v = ($urandom_range(0, 3) != 0);
            s = v && ((!m_active && $urandom_range(0, 1) == 1) || $urandom_range(0, 19999) == 0);
            r = ($urandom_range(0, 29999) == 0);
            drive(r, v, s, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        $display("scenario random: done_l=%0d done_r=%0d err=%0d", cnt_dl, cnt_dr, cnt_err);

`ifdef FRAME_BUF_WRITER_AUTO_EYE_EN
        // Automatic eye: three frames with pix_eye=1 alternate l, r, l
        drive(1, 0, 0, 0, 8'd0);
        clr_counts();
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++) drive(0, 1, (i == 0), 1, 8'($urandom_range(0, 255)));
        chk("auto_done_count", 64'(n_done), 64'd3);
        chk("auto_done_order", 64'(done_order[2:0]), 64'(3'b010));
        $display("scenario auto eye: order=%03b", done_order[2:0]);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
